div_recon_mult: RTL and testbench
=================================

# div_recon_mult

Sequential shift-add reconstruction unit that computes x = q·y + r for the 8-bit quotient, divisor and remainder produced by the 16/8 array divider. It sits beside the exact and approximate divider arrays as the inverse path. Its result lets the error-analysis harness, or an on-chip self-check, compare the reconstructed dividend against the original. It also flags results that are not valid for a division (remainder ≥ divisor, divisor zero).

## Interface
Parameters: none (fixed 8-bit operands, 16-bit result).
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand set offered
- in_ready  out  1  block can accept operands (high only in IDLE)
- q  in  8  quotient operand
- y  in  8  divisor operand
- r  in  8  remainder operand
- out_valid  out  1  result registers hold a completed result
- out_ready  in  1  consumer accepts result
- x  out  16  reconstructed dividend q·y + r
- rem_err  out  1  r ≥ y (invalid remainder; includes y = 0)
- div0  out  1  y == 0

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready = 1. On in_valid && in_ready:
  - latch q and y;
  - accumulator acc[15:0] = {8'h00, r};
  - latch rem_err = (r ≥ y) and div0 = (y == 0);
  - clear bit counter cnt[2:0] = 0;
  - go to RUN.
- RUN: one partial product per cycle, LSB first. If q_reg[cnt] = 1, acc = acc + (y_reg << cnt), as a 16-bit add.
  - The sum never exceeds 16 bits: the maximum is 255·255 + 255 = 65280, so there is no carry-out and no overflow flag.
  - cnt increments. After the cnt = 7 step, go to DONE.
- DONE: out_valid = 1, and x = acc.
  - Outputs x, rem_err and div0 are stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE.
- x, rem_err and div0 are registered outputs. They keep their last value after the handshake until the next result overwrites them at DONE entry.
- in_valid is ignored outside IDLE. Operands q, y and r are sampled only on the accept edge; later changes have no effect.
- Reset (rst_n low at a rising edge), from any state including mid-RUN or DONE:
  - state = IDLE, in_ready = 1;
  - out_valid = 0, x = 0, rem_err = 0, div0 = 0;
  - acc, cnt, q_reg and y_reg are cleared;
  - any operation in progress is discarded, and no result is emitted for it.

## Timing
- Accept edge E0 (in_valid && in_ready sampled high).
- RUN occupies the cycles after E0 through E8; the 8 partial-product edges are E1..E8.
- out_valid rises after E8, giving 8 cycles of latency from the accept edge.
- With out_ready held high:
  - handshake at E9, in_ready rises after E9;
  - next accept is possible at E10;
  - throughput is one result per 10 cycles.
- out_ready high before DONE has no effect. There is no combinational path from any input to any output.
- in_ready and out_valid are never high in the same cycle.

## Test plan
- Nominal case:
  - Stimulus: q=0x4B, y=0xC8, r=0x15, accepted at E0, out_ready=1.
  - Response: out_valid after E8 with x=0x3AAD, rem_err=0, div0=0; in_ready=1 after E9.
- Maximum operands:
  - Stimulus: q=0xFF, y=0xFF, r=0xFE.
  - Response: x=0xFEFF, rem_err=0.
  - Follow-up: r=0xFF with the same q and y gives x=0xFF00, rem_err=1.
- Divide-by-zero:
  - Stimulus: q=0x12, y=0x00, r=0x05.
  - Response: x=0x0005, div0=1, rem_err=1.
- Backpressure:
  - Stimulus: result ready with out_ready held low for 5 cycles while in_valid=1 with new operands.
  - Response: x, rem_err and div0 are unchanged; out_valid=1 and in_ready=0 throughout; no new accept until after the handshake.
- Reset mid-operation:
  - Stimulus: accept q=0xAA, y=0x55, r=0x00; drive rst_n=0 at E4.
  - Response: the next cycle shows in_ready=1, out_valid=0, x=0; no result appears for the aborted operation.
  - Follow-up: a fresh accept of q=0x02, y=0x03, r=0x01 gives x=0x0007.
- Randomized sweep against reference model:
  - Stimulus: random q, y, r with random out_ready stalls.
  - Response: every result equals q·y + r, with rem_err = (r ≥ y) and div0 = (y == 0).

Source files
------------

// File: rtl/div_recon_mult.sv
// Shift-add reconstruction of the dividend x = q*y + r from divider outputs.
// One partial product per cycle, LSB first. It also flags invalid remainders and divide-by-zero.
module div_recon_mult (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  q,
  input  logic [7:0]  y,
  input  logic [7:0]  r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] x,
  output logic        rem_err,
  output logic        div0
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  q_reg, y_reg;
  logic [15:0] acc, acc_nxt, pp;
  logic [2:0]  cnt;
  logic        err_reg, dz_reg;
  logic        accept, last_step, handshake;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last_step = (state == RUN) && (cnt == 3'd7);
  assign handshake = out_valid && out_ready;

  // 255*255 + 255 fits in 16 bits, so the carry-out is dropped safely
  assign pp      = q_reg[cnt] ? ({8'h00, y_reg} << cnt) : 16'h0000;
  assign acc_nxt = acc + pp;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (handshake) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg   <= '0;
      y_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      err_reg <= 1'b0;
      dz_reg  <= 1'b0;
      x       <= '0;
      rem_err <= 1'b0;
      div0    <= 1'b0;
    end else begin
      if (accept) begin
        q_reg   <= q;
        y_reg   <= y;
        acc     <= {8'h00, r};
        cnt     <= '0;
        err_reg <= (r >= y);
        dz_reg  <= (y == 8'h00);
      end else if (state == RUN) begin
        acc <= acc_nxt;
        cnt <= cnt + 3'd1;
      end
      // Result registers change only at DONE entry and hold through backpressure.
      if (last_step) begin
        x       <= acc_nxt;
        rem_err <= err_reg;
        div0    <= dz_reg;
      end
    end
  end

endmodule

// File: tb/tb_div_recon_mult.sv
// Directed and random bench for div_recon_mult: reconstruction, flags, latency,
// backpressure stability and mid-operation reset.
module tb_div_recon_mult;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  q = '0, y = '0, r = '0;
  logic        in_ready, out_valid, rem_err, div0;
  logic [15:0] x;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  div_recon_mult dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .q(q), .y(y), .r(r), .out_valid(out_valid), .out_ready(out_ready),
    .x(x), .rem_err(rem_err), .div0(div0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic accept(input logic [7:0] qa, input logic [7:0] ya, input logic [7:0] ra);
    int k = 0;
    while (!in_ready && k < 50) begin tick; k++; end
    chk("accept_ready", in_ready, 1);
    q = qa; y = ya; r = ra; in_valid = 1'b1;
    tick;
    // operands change after the accept edge must not matter
    in_valid = 1'b0; q = 8'($urandom); y = 8'($urandom); r = 8'($urandom);
  endtask

  task automatic collect(input string tag, input logic [15:0] ex, input logic er,
                         input logic dz, input int stall, input logic bp_valid);
    int k = 0;
    out_ready = (stall == 0);
    while (!out_valid && k < 40) begin
      chk({tag, "_no_ready_while_busy"}, in_ready, 0);
      tick; k++;
    end
    chk({tag, "_latency"}, k, 8);
    chk({tag, "_x"}, x, ex);
    chk({tag, "_rem_err"}, rem_err, er);
    chk({tag, "_div0"}, div0, dz);
    for (int i = 0; i < stall; i++) begin
      if (bp_valid) begin
        in_valid = 1'b1; q = 8'($urandom); y = 8'($urandom); r = 8'($urandom);
      end
      tick;
      chk({tag, "_hold_x"}, x, ex);
      chk({tag, "_hold_flags"}, {rem_err, div0}, {er, dz});
      chk({tag, "_hold_hs"}, {out_valid, in_ready}, 2'b10);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    chk({tag, "_post_hs"}, {out_valid, in_ready}, 2'b01);
    chk({tag, "_keep_x"}, x, ex);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] rq, ry, rr;
    int seen;
    tick; tick;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_x", x, 0);
    chk("rst_flags", {rem_err, div0}, 2'b00);
    rst_n = 1'b1;
    tick;

    // nominal: 75*200+21 = 15021
    accept(8'h4B, 8'hC8, 8'h15); collect("nom", 16'h3AAD, 0, 0, 0, 0);
    // maximum operands
    accept(8'hFF, 8'hFF, 8'hFE); collect("max", 16'hFEFF, 0, 0, 0, 0);
    accept(8'hFF, 8'hFF, 8'hFF); collect("max_r", 16'hFF00, 1, 0, 0, 0);
    // divide by zero
    accept(8'h12, 8'h00, 8'h05); collect("div0", 16'h0005, 1, 1, 0, 0);
    // backpressure with new operands offered: 3*4+2 = 14
    accept(8'h03, 8'h04, 8'h02); collect("bp", 16'h000E, 0, 0, 5, 1);
    chk("bp_no_accept", out_valid, 0);

    // reset mid-RUN at E4
    accept(8'hAA, 8'h55, 8'h00);
    tick; tick; tick;
    rst_n = 1'b0;
    tick;
    chk("mrst_ready", in_ready, 1);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_x", x, 0);
    chk("mrst_flags", {rem_err, div0}, 2'b00);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin tick; if (out_valid) seen++; end
    chk("mrst_no_result", seen, 0);
    accept(8'h02, 8'h03, 8'h01); collect("post_rst", 16'h0007, 0, 0, 0, 0);

    // random sweep against q*y+r
    for (int n = 0; n < 25; n++) begin
      rq = 8'($urandom); ry = 8'($urandom); rr = 8'($urandom);
      if (n % 7 == 3) ry = 8'h00;
      accept(rq, ry, rr);
      collect("rnd", 16'(int'(rq) * int'(ry) + int'(rr)), rr >= ry, ry == 8'h00,
              int'($urandom_range(0, 3)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
